// File: rtl/contador_de_programa.sv
// contador_de_programa
// Program-counter and fetch-sequencing unit. Holds the PC, selects the next
// instruction address from the control unit's pcSource, freezes on HALT and
// holds IN-class instructions until the operator's debounced confirm key is
// pressed and then released. 'stall' gates every datapath write enable, so a
// frozen instruction commits nothing.
module contador_de_programa #(
  parameter int ADDR_W   = 10,
  parameter int DEBOUNCE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rstBios,
  input  logic [1:0]        pcSource,
  input  logic [ADDR_W-1:0] branchTarget,
  input  logic [ADDR_W-1:0] regTarget,
  input  logic [ADDR_W-1:0] jumpTarget,
  input  logic              isHalt,
  input  logic              isInsert,
  input  logic              confirmKey,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pcPlus1,
  output logic              stall,
  output logic              inputAck,
  output logic              halted,
  output logic              waiting
);

  // Counter must be able to hold DEBOUNCE-1 (the last count before the level flips).
  localparam int CNT_W = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);

  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((DEBOUNCE < 1) ? 0 : DEBOUNCE - 1);
  localparam logic [ADDR_W-1:0] PC_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_RUN          = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_WAIT_RELEASE = 2'd2,
    ST_HALTED       = 2'd3
  } state_e;

  // Key path state
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             keyd_q,  keyd_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             key_s;

  // Sequencer state
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q,    pc_d;
  logic [ADDR_W-1:0] npc_s;

  // Synchronizer next values: the pin is active-low, so invert on entry and
  // let a released key read as 0 all the way down the chain.
  always_comb begin
    sync1_d = sync1_q;
    sync2_d = sync2_q;
    if (rstBios) begin
      sync1_d = 1'b0;
      sync2_d = 1'b0;
    end else begin
      sync1_d = ~confirmKey;
      sync2_d = sync1_q;
    end
  end

  assign key_s = sync2_q;

  // Debouncer: the accepted level only follows key_s after it has disagreed
  // for DEBOUNCE consecutive cycles; any agreement restarts the count.
  always_comb begin
    keyd_d = keyd_q;
    cnt_d  = cnt_q;
    if (rstBios) begin
      keyd_d = 1'b0;
      cnt_d  = CNT_ZERO;
    end else if (key_s == keyd_q) begin
      cnt_d = CNT_ZERO;
    end else if (cnt_q == CNT_LAST) begin
      keyd_d = key_s;
      cnt_d  = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Key-path flops: synchronizer, debounced level and stability counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      keyd_q  <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      keyd_q  <= keyd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-PC select; the increment wraps naturally at 2^ADDR_W.
  always_comb begin
    npc_s = pc_q + PC_ONE;
    case (pcSource)
      2'b00:   npc_s = pc_q + PC_ONE;
      2'b01:   npc_s = branchTarget;
      2'b10:   npc_s = regTarget;
      2'b11:   npc_s = jumpTarget;
      default: npc_s = pc_q + PC_ONE;
    endcase
  end

  // Sequencer next state and PC. HALT outranks an input wait; the PC only
  // moves in RUN or on the single confirm cycle of WAIT_PRESS.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (rstBios) begin
      state_d = ST_RUN;
      pc_d    = PC_ZERO;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (isHalt) begin
            state_d = ST_HALTED;
          end else if (isInsert) begin
            state_d = ST_WAIT_PRESS;
          end else begin
            pc_d = npc_s;
          end
        end
        ST_WAIT_PRESS: begin
          if (keyd_q) begin
            pc_d    = npc_s;
            state_d = ST_WAIT_RELEASE;
          end else begin
            state_d = ST_WAIT_PRESS;
          end
        end
        ST_WAIT_RELEASE: begin
          // Returning to RUN does not advance the PC; the next instruction
          // starts on the following cycle.
          if (!keyd_q) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_WAIT_RELEASE;
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        default: begin
          state_d = ST_RUN;
          pc_d    = pc_q;
        end
      endcase
    end
  end

  // Sequencer state and PC register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      pc_q    <= PC_ZERO;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Output decode from the current state; inputAck and stall also look at the
  // debounced key so the confirm cycle commits its writes.
  always_comb begin
    pc       = pc_q;
    pcPlus1  = pc_q + PC_ONE;
    stall    = 1'b0;
    inputAck = 1'b0;
    halted   = 1'b0;
    waiting  = 1'b0;
    case (state_q)
      ST_RUN: begin
        stall = isHalt | isInsert;
      end
      ST_WAIT_PRESS: begin
        stall    = ~keyd_q;
        inputAck = keyd_q;
        waiting  = 1'b1;
      end
      ST_WAIT_RELEASE: begin
        stall   = 1'b1;
        waiting = 1'b1;
      end
      ST_HALTED: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: begin
        stall = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_contador_de_programa.sv
// Self-checking bench for contador_de_programa: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the unit.
module tb_contador_de_programa;

  localparam int AW     = 10;
  localparam int DEB    = 4;
  localparam int PC_MOD = 1 << AW;

  localparam int M_RUN  = 0;
  localparam int M_WP   = 1;
  localparam int M_WR   = 2;
  localparam int M_HALT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          rstBios;
  logic [1:0]    pcSource;
  logic [AW-1:0] branchTarget;
  logic [AW-1:0] regTarget;
  logic [AW-1:0] jumpTarget;
  logic          isHalt;
  logic          isInsert;
  logic          confirmKey;
  logic [AW-1:0] pc;
  logic [AW-1:0] pcPlus1;
  logic          stall;
  logic          inputAck;
  logic          halted;
  logic          waiting;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int m_pc;
  int m_mode;
  bit m_keyd;
  bit pin_dly [2];
  bit ks_hist [$];

  // Last observed values (for directed counting)
  bit last_ack;
  bit last_wait;

  contador_de_programa #(.ADDR_W(AW), .DEBOUNCE(DEB)) dut (
    .clk(clk), .rst(rst), .rstBios(rstBios), .pcSource(pcSource),
    .branchTarget(branchTarget), .regTarget(regTarget), .jumpTarget(jumpTarget),
    .isHalt(isHalt), .isInsert(isInsert), .confirmKey(confirmKey),
    .pc(pc), .pcPlus1(pcPlus1), .stall(stall), .inputAck(inputAck),
    .halted(halted), .waiting(waiting)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc   = 0;
    m_mode = M_RUN;
    m_keyd = 1'b0;
    pin_dly[0] = 1'b0;
    pin_dly[1] = 1'b0;
    ks_hist.delete();
  endtask

  function automatic int model_npc();
    case (pcSource)
      2'd0:    return (m_pc + 1) % PC_MOD;
      2'd1:    return int'(branchTarget);
      2'd2:    return int'(regTarget);
      default: return int'(jumpTarget);
    endcase
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit ks;
    bit flip;
    if (!rst || rstBios) begin
      model_reset();
      return;
    end
    ks = pin_dly[1];
    case (m_mode)
      M_RUN: begin
        if (isHalt)        m_mode = M_HALT;
        else if (isInsert) m_mode = M_WP;
        else               m_pc = model_npc();
      end
      M_WP: if (m_keyd) begin
        m_pc   = model_npc();
        m_mode = M_WR;
      end
      M_WR: if (!m_keyd) m_mode = M_RUN;
      default: ;
    endcase
    // Accepted level flips once the last DEB synchronized samples all disagree with it.
    ks_hist.push_back(ks);
    if (ks_hist.size() > DEB) void'(ks_hist.pop_front());
    flip = (ks_hist.size() == DEB);
    foreach (ks_hist[i]) if (ks_hist[i] == m_keyd) flip = 1'b0;
    if (flip) m_keyd = ~m_keyd;
    pin_dly[1] = pin_dly[0];
    pin_dly[0] = ~confirmKey;
  endtask

  // One clock cycle: check outputs mid-cycle, then step the model at the edge.
  task automatic cyc();
    bit exp_stall;
    @(negedge clk);
    exp_stall = (m_mode == M_RUN && (isHalt || isInsert)) || (m_mode == M_WP && !m_keyd) ||
                (m_mode == M_WR) || (m_mode == M_HALT);
    check("pc", pc, m_pc);
    check("pcPlus1", pcPlus1, (m_pc + 1) % PC_MOD);
    check("stall", stall, exp_stall);
    check("inputAck", inputAck, (m_mode == M_WP) && m_keyd);
    check("halted", halted, m_mode == M_HALT);
    check("waiting", waiting, (m_mode == M_WP) || (m_mode == M_WR));
    last_ack  = inputAck;
    last_wait = waiting;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic go_to(input int a);
    pcSource   = 2'd3;
    jumpTarget = AW'(a);
    isHalt     = 1'b0;
    isInsert   = 1'b0;
    cyc();
    pcSource   = 2'd0;
  endtask

  initial begin
    int ack_at;
    int wcnt;
    int acks;
    int pc_hold;
    int key_left;

    rst = 1'b0; rstBios = 1'b0; pcSource = 2'd0;
    branchTarget = '0; regTarget = '0; jumpTarget = '0;
    isHalt = 1'b0; isInsert = 1'b1; confirmKey = 1'b1;
    model_reset();
    cyc();
    cyc();
    check("rst_pc", pc, 0);
    check("rst_pc1", pcPlus1, 1);
    check("rst_stall", stall, 1);
    check("rst_ack", inputAck, 0);
    check("rst_halted", halted, 0);
    check("rst_waiting", waiting, 0);
    rst = 1'b1;
    isInsert = 1'b0;

    // Sequential fetch
    for (int i = 0; i < 5; i++) cyc();
    check("fetch5", pc, 5);
    check("fetch_stall", stall, 0);

    // Jump selects from pc=4
    go_to(4); pcSource = 2'd1; branchTarget = AW'(40); cyc();
    check("branch", pc, 40);
    go_to(4); pcSource = 2'd2; regTarget = AW'(77); cyc();
    check("regjump", pc, 77);
    go_to(4); pcSource = 2'd3; jumpTarget = AW'(9); cyc();
    check("jump", pc, 9);
    go_to(PC_MOD - 1);
    check("wrap_plus1", pcPlus1, 0);
    pcSource = 2'd0; cyc();
    check("wrap", pc, 0);

    // Input wait with press latency and release wait
    go_to(6); isInsert = 1'b1; cyc(); isInsert = 1'b0;
    check("wp_pc", pc, 6);
    check("wp_wait", waiting, 1);
    confirmKey = 1'b0;
    ack_at = -1;
    for (int i = 0; i < 40 && ack_at < 0; i++) begin
      cyc();
      if (last_ack) ack_at = i;
    end
    check("ack_latency", ack_at, 2 + DEB);
    check("ack_pc", pc, 7);
    confirmKey = 1'b1;
    wcnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (!last_wait) break;
      wcnt++;
    end
    check("release_wait", wcnt, 3 + DEB);

    // Bounce rejection in WAIT_PRESS
    isInsert = 1'b1; cyc(); isInsert = 1'b0;
    pc_hold = int'(pc);
    acks = 0;
    for (int len = 1; len <= DEB - 1; len++) begin
      confirmKey = 1'b0;
      for (int i = 0; i < len; i++) begin cyc(); acks += int'(last_ack); end
      confirmKey = 1'b1;
      for (int i = 0; i < 8; i++) begin cyc(); acks += int'(last_ack); end
    end
    check("bounce_acks", acks, 0);
    check("bounce_pc", pc, pc_hold);
    check("bounce_wait", waiting, 1);
    confirmKey = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    confirmKey = 1'b1;
    for (int i = 0; i < 10; i++) cyc();

    // Halt, then soft reset
    go_to(12); isHalt = 1'b1; cyc();
    for (int i = 0; i < 100; i++) begin
      isHalt   = 1'($urandom_range(0, 1));
      isInsert = 1'($urandom_range(0, 1));
      pcSource = 2'($urandom_range(0, 3));
      jumpTarget = AW'($urandom_range(0, PC_MOD - 1));
      cyc();
    end
    check("halt_pc", pc, 12);
    check("halt_flag", halted, 1);
    isHalt = 1'b0; isInsert = 1'b0; pcSource = 2'd0;
    rstBios = 1'b1; cyc(); rstBios = 1'b0;
    check("bios_pc", pc, 0);
    check("bios_halted", halted, 0);

    // Async reset in the middle of a press debounce
    go_to(20); isInsert = 1'b1; cyc(); isInsert = 1'b0;
    confirmKey = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    #2 rst = 1'b0;
    #1;
    check("arst_pc", pc, 0);
    check("arst_waiting", waiting, 0);
    check("arst_ack", inputAck, 0);
    model_reset();
    cyc();
    rst = 1'b1;
    confirmKey = 1'b1;
    for (int i = 0; i < 4; i++) cyc();

    // Randomized traffic
    key_left = 0;
    for (int n = 0; n < 3000; n++) begin
      pcSource     = 2'($urandom_range(0, 3));
      branchTarget = AW'($urandom_range(0, PC_MOD - 1));
      regTarget    = AW'($urandom_range(0, PC_MOD - 1));
      jumpTarget   = AW'($urandom_range(0, PC_MOD - 1));
      isInsert     = ($urandom_range(0, 5) == 0);
      isHalt       = ($urandom_range(0, 79) == 0);
      rstBios      = ($urandom_range(0, 59) == 0);
      if (key_left == 0) begin
        confirmKey = 1'($urandom_range(0, 1));
        key_left   = $urandom_range(1, 12);
      end
      key_left--;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
